// File: rtl/sqrt_param.sv
// sqrt_param: sequential integer square root, bit-serial restoring method.
//
// Computes y = floor(sqrt(a)) for an unsigned WIDTH-bit radicand. One result
// bit is resolved per clock, so a computation occupies WIDTH/2 cycles in CALC
// and then returns to IDLE, pulsing done_o for one cycle.
//
// Parameters:
//   WIDTH    radicand width, even and >= 4 (default 16)
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   start_i  launch a computation (sampled only while ready_o is high)
//   a_bi     unsigned radicand, captured at the start edge
//   ready_o  idle and able to accept start_i
//   busy_o   computation in progress
//   done_o   one-cycle pulse when y_bo (and rem_bo) update
//   y_bo     floor(sqrt(a)) of the last completed computation
//   rem_bo   a - y*y of the last completed computation
//
// Configuration:
//   SQRT_REM_EN  when defined, the remainder register and rem_bo port exist;
//                when undefined, rem_bo is absent and y_bo timing is identical.
module sqrt_param #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_bi,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH/2-1:0] y_bo
`ifdef SQRT_REM_EN
  ,
  output logic [WIDTH/2:0]   rem_bo
`endif
);

  localparam int unsigned Half = WIDTH / 2;
  localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Half - 1);
  // Highest even bit position: the first trial bit of the result squared.
  localparam logic [WIDTH-1:0] MInit = {2'b01, {(WIDTH - 2){1'b0}}};

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : gen_width_check
    $error("sqrt_param: WIDTH must be even and >= 4");
  end

  typedef enum logic {StIdle, StCalc} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;     // running remainder
  logic [WIDTH-1:0] acc_q, acc_d; // partial root, pre-scaled by m
  logic [WIDTH-1:0] m_q, m_d;     // current trial bit (squared position)
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Half-1:0]  y_q, y_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] trial;
`ifdef SQRT_REM_EN
  logic [Half:0]    rem_q, rem_d;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    done_d  = 1'b0;
`ifdef SQRT_REM_EN
    rem_d   = rem_q;
`endif
    trial   = acc_q | m_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          x_d     = a_bi;
          acc_d   = '0;
          m_d     = MInit;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = acc_q >> 1;
        if (x_q >= trial) begin
          x_d   = x_q - trial;
          // Accept this result bit; m and the shifted acc never overlap.
          acc_d = (acc_q >> 1) | m_q;
        end
        m_d   = m_q >> 2;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // After the last iteration acc holds the root and x the remainder,
          // both small enough to fit the narrow output registers.
          y_d     = acc_d[Half-1:0];
`ifdef SQRT_REM_EN
          rem_d   = x_d[Half:0];
`endif
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      x_q     <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
`ifdef SQRT_REM_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      done_q  <= done_d;
`ifdef SQRT_REM_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign ready_o = (state_q == StIdle);
  assign busy_o  = (state_q == StCalc);
  assign done_o  = done_q;
  assign y_bo    = y_q;
`ifdef SQRT_REM_EN
  assign rem_bo  = rem_q;
`endif

endmodule

// File: tb/tb_sqrt_param.sv
// Self-checking bench for sqrt_param at WIDTH=16 and WIDTH=32. Expected roots
// come from a square-test reference; remainders from a - y*y.
module tb_sqrt_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start16, ready16, busy16, done16;
  logic [15:0] a16;
  logic [7:0]  y16;
  logic        start32, ready32, busy32, done32;
  logic [31:0] a32;
  logic [15:0] y32;
`ifdef SQRT_REM_EN
  logic [8:0]  rem16;
  logic [16:0] rem32;
`endif

  sqrt_param #(.WIDTH(16)) dut16 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start16),
    .a_bi    (a16),
    .ready_o (ready16),
    .busy_o  (busy16),
    .done_o  (done16),
    .y_bo    (y16)
`ifdef SQRT_REM_EN
    ,
    .rem_bo  (rem16)
`endif
  );

  sqrt_param #(.WIDTH(32)) dut32 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start32),
    .a_bi    (a32),
    .ready_o (ready32),
    .busy_o  (busy32),
    .done_o  (done32),
    .y_bo    (y32)
`ifdef SQRT_REM_EN
    ,
    .rem_bo  (rem32)
`endif
  );

  int checks = 0;
  int failures = 0;
  int done_cnt16 = 0;

  always @(negedge clk) if (done16) done_cnt16++;

  task automatic check_eq(input string tag, input longint unsigned got,
                          input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Largest y with y*y <= a, built from the top bit down by squaring.
  function automatic longint unsigned isqrt(input longint unsigned a);
    longint unsigned y = 0;
    for (int b = 31; b >= 0; b--) begin
      longint unsigned t = y | (64'd1 << b);
      if (t * t <= a) y = t;
    end
    return y;
  endfunction

  // Caller is #1 after an edge with dut16 idle. Returns #1 after the edge
  // on which done16 is seen; a16 is scrambled after the start edge.
  task automatic run16(input logic [15:0] a, output int lat, output int busy_n,
                       output int y_moved);
    logic [7:0] y_prev;
    y_prev  = y16;
    a16     = a;
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    a16     = 16'($urandom);
    lat     = 1;
    busy_n  = 0;
    y_moved = 0;
    while (!done16 && lat < 100) begin
      if (busy16) busy_n++;
      if (y16 !== y_prev) y_moved++;
      @(posedge clk); #1;
      lat++;
    end
    lat--;  // the start edge itself is not part of the latency
  endtask

  task automatic check16(input string tag, input logic [15:0] a, input int lat,
                         input int busy_n, input int y_moved);
    longint unsigned ey;
    ey = isqrt(a);
    check_eq({tag, "_y"}, y16, ey);
`ifdef SQRT_REM_EN
    check_eq({tag, "_rem"}, rem16, a - ey * ey);
`endif
    check_eq({tag, "_lat"}, lat, 8);
    check_eq({tag, "_busy"}, busy_n, 8);
    check_eq({tag, "_hold"}, y_moved, 0);
  endtask

  task automatic run32(input logic [31:0] a, input string tag);
    int lat, busy_n;
    longint unsigned ey;
    a32     = a;
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    a32     = $urandom;
    lat     = 0;
    busy_n  = 0;
    while (!done32 && lat < 100) begin
      if (busy32) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    ey = isqrt(a);
    check_eq({tag, "_y"}, y32, ey);
`ifdef SQRT_REM_EN
    check_eq({tag, "_rem"}, rem32, a - ey * ey);
`endif
    check_eq({tag, "_lat"}, lat, 16);
    check_eq({tag, "_busy"}, busy_n, 16);
  endtask

  initial begin
    int lat, busy_n, moved, base, n;
    logic [7:0] y_keep;
    int fixed[10] = '{25, 2, 0, 65535, 16, 1, 3, 4, 65025, 65024};

    rst = 1'b1; start16 = 1'b0; a16 = '0; start32 = 1'b0; a32 = '0;
    #12;
    check_eq("rst_ready", ready16, 1);
    check_eq("rst_busy", busy16, 0);
    check_eq("rst_done", done16, 0);
    check_eq("rst_y", y16, 0);
    check_eq("rst_ready32", ready32, 1);
`ifdef SQRT_REM_EN
    check_eq("rst_rem", rem16, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // First start lands on the very first edge after reset release.
    foreach (fixed[i]) begin
      run16(16'(fixed[i]), lat, busy_n, moved);
      check16($sformatf("fix%0d", fixed[i]), 16'(fixed[i]), lat, busy_n, moved);
    end

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      int gap;
      a   = 16'($urandom_range(0, 65535));
      gap = $urandom_range(0, 3);
      y_keep = y16;
      repeat (gap) begin @(posedge clk); #1; end
      check_eq("idle_hold", y16, y_keep);
      run16(a, lat, busy_n, moved);
      check16("rnd", a, lat, busy_n, moved);
    end

    // a changes and start re-pulses mid-CALC: one run, original operand.
    repeat (2) begin @(posedge clk); #1; end
    base = done_cnt16;
    a16 = 16'd9; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    a16 = 16'd100; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    check_eq("ignore_y", y16, 3);
    check_eq("ignore_dones", done_cnt16 - base, 1);
    check_eq("ignore_idle", ready16, 1);

    // Asynchronous reset in the middle of CALC.
    a16 = 16'd144; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    base = done_cnt16;
    #2 rst = 1'b1;
    #1;
    check_eq("abort_y", y16, 0);
    check_eq("abort_busy", busy16, 0);
    check_eq("abort_ready", ready16, 1);
    check_eq("abort_done", done16, 0);
`ifdef SQRT_REM_EN
    check_eq("abort_rem", rem16, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    check_eq("abort_nodone", done_cnt16 - base, 0);
    check_eq("abort_wait", ready16, 1);
    run16(16'd144, lat, busy_n, moved);
    check16("after_abort", 16'd144, lat, busy_n, moved);

    // start held high: 49 then 50 back-to-back. The done cycle is an idle
    // cycle that relaunches, so results repeat every WIDTH/2+1 edges.
    a16 = 16'd49; start16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'd50;
    n = 0;
    while (!done16 && n < 100) begin @(posedge clk); #1; n++; end
    check_eq("b2b_lat1", n, 8);
    check_eq("b2b_y1", y16, 7);
`ifdef SQRT_REM_EN
    check_eq("b2b_rem1", rem16, 0);
`endif
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done16 && n < 100);
    start16 = 1'b0;
    check_eq("b2b_period", n, 9);
    check_eq("b2b_y2", y16, 7);
`ifdef SQRT_REM_EN
    check_eq("b2b_rem2", rem16, 1);
`endif
    @(posedge clk); #1;
    check_eq("b2b_stop", busy16, 0);

    run32(32'hFFFF_FFFF, "w32_max");
    run32(32'd0, "w32_zero");
    for (int i = 0; i < 6; i++) run32($urandom, "w32_rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
